// File: rtl/autoscale_pkg.sv
// Shared definitions for the CORDIC autoscale front end: mode encodings
// and the shift-amount rule derived from a found bit index.
package autoscale_pkg;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    // MSB mode moves the found bit up to the top; LSB mode moves it down to bit 0.
    function automatic int shift_amount(input int index, input int width, input logic mode);
        if (mode == MODE_MSB) begin
            return width - 1 - index;
        end
        return index;
    endfunction

endpackage

// File: rtl/lead_one_encoder.sv
// Combinational first-one finder: highest set bit (MSB mode) or lowest
// set bit (LSB mode) of vec. index is 0 when vec is all zero; zero flags that case.
module lead_one_encoder
    import autoscale_pkg::*;
#(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = $clog2(DIN_WIDTH)
) (
    input  logic [DIN_WIDTH-1:0]  vec,
    input  logic                  mode,
    output logic [DOUT_WIDTH-1:0] index,
    output logic                  zero
);

    // Priority scan: the last set bit visited wins, so scan order picks the end.
    always_comb begin
        index = '0;
        zero  = ~|vec;
        if (mode == MODE_MSB) begin
            for (int i = 0; i < DIN_WIDTH; i++) begin
                if (vec[i]) index = DOUT_WIDTH'(i);
            end
        end else begin
            for (int i = DIN_WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) index = DOUT_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/first_one_normalizer.sv
// Three-stage common-scale normaliser for multi-lane CORDIC inputs.
// S1 registers input and OR of lanes, S2 finds the first one and shift,
// S3 barrel-shifts all lanes by the same amount and registers outputs.
// Build option FIRST_ONE_SHIFT_EN: when undefined the shifter and the data
// pipeline are removed and dout_data is tied to 0; control timing is unchanged.
module first_one_normalizer
    import autoscale_pkg::*;
#(
    parameter int DIN_WIDTH  = 32,
    parameter int CHANNELS   = 2,
    parameter int DOUT_WIDTH = $clog2(DIN_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*DIN_WIDTH-1:0]  din,
    input  logic                           din_valid,
    input  logic                           mode,
    output logic [DOUT_WIDTH-1:0]          dout_index,
    output logic [DOUT_WIDTH-1:0]          dout_shift,
    output logic                           dout_zero,
    output logic [CHANNELS*DIN_WIDTH-1:0]  dout_data,
    output logic                           dout_valid
);

    localparam int LW = CHANNELS * DIN_WIDTH;

    logic [DIN_WIDTH-1:0]  comb_p1_d, comb_p1_q;
    logic                  mode_p1_q, vld_p1_q;
    logic [DOUT_WIDTH-1:0] enc_index;
    logic                  enc_zero;
    logic [DOUT_WIDTH-1:0] shift_p2_d, shift_p2_q, index_p2_q;
    logic                  zero_p2_q, vld_p2_q;
    logic [DOUT_WIDTH-1:0] index_p3_q, shift_p3_q;
    logic                  zero_p3_q, vld_p3_q;

    // S1: combined vector is the OR of all lanes so every lane shares one scale.
    always_comb begin
        comb_p1_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            comb_p1_d = comb_p1_d | din[k*DIN_WIDTH +: DIN_WIDTH];
        end
    end

    // S1 control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comb_p1_q <= '0;
            mode_p1_q <= 1'b0;
            vld_p1_q  <= 1'b0;
        end else begin
            comb_p1_q <= comb_p1_d;
            mode_p1_q <= mode;
            vld_p1_q  <= din_valid;
        end
    end

    lead_one_encoder #(
        .DIN_WIDTH  (DIN_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_enc (
        .vec   (comb_p1_q),
        .mode  (mode_p1_q),
        .index (enc_index),
        .zero  (enc_zero)
    );

    // S2: an all-zero sample must report shift 0, not the MSB-mode formula.
    always_comb begin
        shift_p2_d = '0;
        if (!enc_zero) begin
            shift_p2_d = DOUT_WIDTH'(shift_amount(int'(enc_index), DIN_WIDTH, mode_p1_q));
        end
    end

    // S2 control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_p2_q <= '0;
            shift_p2_q <= '0;
            zero_p2_q  <= 1'b0;
            vld_p2_q   <= 1'b0;
        end else begin
            index_p2_q <= enc_index;
            shift_p2_q <= shift_p2_d;
            zero_p2_q  <= enc_zero;
            vld_p2_q   <= vld_p1_q;
        end
    end

    // S3 control/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_p3_q <= '0;
            shift_p3_q <= '0;
            zero_p3_q  <= 1'b0;
            vld_p3_q   <= 1'b0;
        end else begin
            index_p3_q <= index_p2_q;
            shift_p3_q <= shift_p2_q;
            zero_p3_q  <= zero_p2_q;
            vld_p3_q   <= vld_p2_q;
        end
    end

    assign dout_index = index_p3_q;
    assign dout_shift = shift_p3_q;
    assign dout_zero  = zero_p3_q;
    assign dout_valid = vld_p3_q;

`ifdef FIRST_ONE_SHIFT_EN
    logic [LW-1:0] din_p1_q, data_p2_q, data_p3_d, data_p3_q;
    logic          mode_p2_q;

    // Data pipeline: raw lanes travel alongside the control path through S1/S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_p1_q  <= '0;
            data_p2_q <= '0;
            mode_p2_q <= 1'b0;
            data_p3_q <= '0;
        end else begin
            din_p1_q  <= din;
            data_p2_q <= din_p1_q;
            mode_p2_q <= mode_p1_q;
            data_p3_q <= data_p3_d;
        end
    end

    // S3: shift direction cannot drop set bits because the shift targets the combined first one.
    always_comb begin
        data_p3_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mode_p2_q == MODE_MSB) begin
                data_p3_d[k*DIN_WIDTH +: DIN_WIDTH] = data_p2_q[k*DIN_WIDTH +: DIN_WIDTH] << shift_p2_q;
            end else begin
                data_p3_d[k*DIN_WIDTH +: DIN_WIDTH] = data_p2_q[k*DIN_WIDTH +: DIN_WIDTH] >> shift_p2_q;
            end
        end
    end

    assign dout_data = data_p3_q;
`else
    assign dout_data = '0;
`endif

endmodule

// File: tb/tb_first_one_normalizer.sv
// Randomised plus directed bench for first_one_normalizer (32-bit, 2 lanes).
module tb_first_one_normalizer;

    localparam int DW = 32;
    localparam int CH = 2;
    localparam int OW = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [CH*DW-1:0]   din;
    logic               din_valid;
    logic               mode;
    logic [OW-1:0]      dout_index;
    logic [OW-1:0]      dout_shift;
    logic               dout_zero;
    logic [CH*DW-1:0]   dout_data;
    logic               dout_valid;

    typedef struct {
        bit          vld;
        bit          m;
        logic [63:0] d;
    } smp_t;

    smp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    first_one_normalizer #(.DIN_WIDTH(DW), .CHANNELS(CH), .DOUT_WIDTH(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .mode       (mode),
        .dout_index (dout_index),
        .dout_shift (dout_shift),
        .dout_zero  (dout_zero),
        .dout_data  (dout_data),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: index is floor(log2) of the OR (MSB) or its trailing-zero count (LSB).
    function automatic void model(input logic [63:0] d, input bit m, output int idx,
                                  output int sh, output bit z, output logic [63:0] od);
        logic [31:0] a, b;
        longint unsigned v;
        a = d[31:0];
        b = d[63:32];
        v = longint'(a | b);
        z = (v == 0);
        idx = 0;
        if (!z) begin
            if (!m) begin
                while (v > 1) begin v = v / 2; idx++; end
            end else begin
                while (v % 2 == 0) begin v = v / 2; idx++; end
            end
        end
        sh = z ? 0 : (m ? idx : DW - 1 - idx);
        if (m) od = {b >> sh, a >> sh};
        else   od = {b << sh, a << sh};
    endfunction

    task automatic check_out(input smp_t s);
        int idx, sh;
        bit z;
        logic [63:0] od;
        chk("valid", 64'(dout_valid), 64'(s.vld));
        if (s.vld) begin
            model(s.d, s.m, idx, sh, z, od);
            chk("index", 64'(dout_index), 64'(idx));
            chk("shift", 64'(dout_shift), 64'(sh));
            chk("zero", 64'(dout_zero), 64'(z));
`ifdef FIRST_ONE_SHIFT_EN
            chk("data", dout_data, od);
`else
            chk("data", dout_data, 64'd0);
`endif
        end
    endtask

    // One clock: check the sample due now, then drive and record the next one.
    task automatic step(input bit v, input bit m, input logic [63:0] d);
        smp_t s;
        @(posedge clk);
        #1;
        if (q.size() == 3) check_out(q.pop_front());
        din_valid = v;
        mode = m;
        din = d;
        s.vld = v; s.m = m; s.d = d;
        q.push_back(s);
    endtask

    task automatic prefill();
        smp_t s;
        q.delete();
        s.vld = 0; s.m = 0; s.d = '0;
        repeat (3) q.push_back(s);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
        chk({tag, "_index"}, 64'(dout_index), 64'd0);
        chk({tag, "_shift"}, 64'(dout_shift), 64'd0);
        chk({tag, "_zero"}, 64'(dout_zero), 64'd0);
        chk({tag, "_data"}, dout_data, 64'd0);
    endtask

    function automatic logic [31:0] rlane();
        int r = $urandom_range(0, 7);
        if (r == 0) return 32'd0;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    initial begin
        rst_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        mode = 1'b0;
        #1;
        chk_all_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prefill();

        // Directed scenarios
        step(1, 0, {32'h0000_0300, 32'h0000_1000});
        step(1, 1, {32'h0000_0300, 32'h0000_1000});
        step(1, 0, 64'd0);
        step(1, 1, 64'd0);
        step(1, 0, {32'h0000_0000, 32'h0000_0001});
        step(1, 1, {32'h8000_0000, 32'h0000_0000});
        step(1, 0, {32'hFFFF_FFFF, 32'h0000_0000});
        // Streaming with bubbles and toggling mode
        step(1, 0, {32'h0000_00F0, 32'h0001_0000});
        step(0, 1, {32'h1234_5678, 32'h0000_0001});
        step(1, 0, {32'h0000_0002, 32'h0000_0040});
        step(1, 1, {32'h0100_0000, 32'h0040_0000});

        // Asynchronous reset with three valid samples in flight
        step(1, 0, {32'h0000_0010, 32'h0000_0001});
        step(1, 1, {32'h0000_0300, 32'h0000_1000});
        step(1, 0, {32'h0000_0000, 32'h0000_8000});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        din_valid = 1'b0;
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        prefill();
        repeat (3) step(0, 0, $urandom);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), {rlane(), rlane()});
        end
        repeat (3) step(0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
